// File: rtl/v_upd_ingress_pkg.sv
// Shared types for the update-pipe ingress: command encoding, field widths and the FIFO word.
package v_pkg;

  typedef logic [3:0]  id_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_INSERT  = 2'd1,
    CMD_DELETE  = 2'd2,
    CMD_REPLACE = 2'd3
  } cmd_t;

  localparam int unsigned UPD_HAZARD_WIN = 3;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

endpackage

// File: rtl/v_upd_ingress_if.sv
// Producer handshake and update-bus signals of the ingress stage, named from the ingress point of view.
interface v_upd_ingress_if;
  import v_pkg::*;

  logic  i_in_vld;
  logic  o_in_rdy;
  id_t   i_in_prod_id;
  cmd_t  i_in_cmd;
  key_t  i_in_key;
  size_t i_in_size;

  logic  o_upd_vld;
  id_t   o_upd_prod_id;
  cmd_t  o_upd_cmd;
  key_t  o_upd_key;
  size_t o_upd_size;

  modport slave (
    input  i_in_vld, i_in_prod_id, i_in_cmd, i_in_key, i_in_size,
    output o_in_rdy,
    output o_upd_vld, o_upd_prod_id, o_upd_cmd, o_upd_key, o_upd_size
  );

  modport master (
    output i_in_vld, i_in_prod_id, i_in_cmd, i_in_key, i_in_size,
    input  o_in_rdy,
    input  o_upd_vld, o_upd_prod_id, o_upd_cmd, o_upd_key, o_upd_size
  );

endinterface

// File: rtl/v_upd_fifo.sv
// Flop-array FIFO of update commands; head is presented combinationally from the read pointer.
module v_upd_fifo
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  upd_t                       i_data,
  input  logic                       i_pop,
  output upd_t                       o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  upd_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/v_upd_ingress.sv
// Ingress stage ahead of the update pipe: buffers producer commands, issues them in order and
// keeps a per-context hazard window so one prod_id is not re-issued within HAZARD_WIN cycles.
module v_upd_ingress
  import v_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HAZARD_WIN = UPD_HAZARD_WIN
) (
  input  logic                       clk,
  input  logic                       rst,
  v_upd_ingress_if.slave             bus,
  output logic                       o_hazard_stall,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
);

  localparam int unsigned HD = (HAZARD_WIN > 0) ? HAZARD_WIN : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("v_upd_ingress: DEPTH must be a power of 2 and >= 2");
  end

  upd_t  w_in;
  upd_t  w_head;
  logic  w_empty;
  logic  w_full;
  logic  w_push;
  logic  w_pop;
  logic  w_blocked;

  // Stage 0 of the history is the output register itself.
  logic  r_hist_vld [HD];
  id_t   r_hist_id  [HD];
  cmd_t  r_upd_cmd;
  key_t  r_upd_key;
  size_t r_upd_size;

  assign w_in = '{prod_id: bus.i_in_prod_id, cmd: bus.i_in_cmd,
                  key: bus.i_in_key, size: bus.i_in_size};

  assign bus.o_in_rdy = !w_full;
  assign w_push       = bus.i_in_vld && !w_full && (bus.i_in_cmd != CMD_NOP);

  v_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (o_occ)
  );

  always_comb begin
    w_blocked = 1'b0;
    for (int unsigned k = 0; k < HAZARD_WIN; k++) begin
      if (r_hist_vld[k] && (r_hist_id[k] == w_head.prod_id)) begin
        w_blocked = 1'b1;
      end
    end
  end

  assign w_pop          = !w_empty && !w_blocked;
  assign o_hazard_stall = !w_empty && w_blocked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < HD; k++) begin
        r_hist_vld[k] <= 1'b0;
        r_hist_id[k]  <= '0;
      end
      r_upd_cmd  <= CMD_NOP;
      r_upd_key  <= '0;
      r_upd_size <= '0;
    end else begin
      r_hist_vld[0] <= w_pop;
      if (w_pop) begin
        r_hist_id[0] <= w_head.prod_id;
        r_upd_cmd    <= w_head.cmd;
        r_upd_key    <= w_head.key;
        r_upd_size   <= w_head.size;
      end
      for (int unsigned k = 1; k < HD; k++) begin
        r_hist_vld[k] <= r_hist_vld[k-1];
        r_hist_id[k]  <= r_hist_id[k-1];
      end
    end
  end

  assign bus.o_upd_vld     = r_hist_vld[0];
  assign bus.o_upd_prod_id = r_hist_id[0];
  assign bus.o_upd_cmd     = r_upd_cmd;
  assign bus.o_upd_key     = r_upd_key;
  assign bus.o_upd_size    = r_upd_size;

endmodule

// File: tb/tb_v_upd_ingress.sv
// Bench for v_upd_ingress: directed scenarios plus random traffic against a queue/issue-time model.
module tb_v_upd_ingress;
  import v_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int          HW    = 3;
  localparam int          NEVER = -1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall;
  logic [3:0] occ;

  v_upd_ingress_if bus();

  v_upd_ingress #(
    .DEPTH      (DEPTH),
    .HAZARD_WIN (HW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_hazard_stall (stall),
    .o_occ          (occ)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  upd_t mq [$];
  int   last_out [16];
  logic m_vld;
  upd_t m_out;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit m_blocked();
    if (mq.size() == 0) return 1'b0;
    return cyc < last_out[mq[0].prod_id] + HW;
  endfunction

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) last_out[i] = NEVER;
    m_vld = 1'b0;
    m_out = '0;
  endfunction

  function automatic upd_t mk(input int id, input cmd_t c, input int key, input int size);
    upd_t u;
    u.prod_id = id_t'(id);
    u.cmd     = c;
    u.key     = key_t'(key);
    u.size    = size_t'(size);
    return u;
  endfunction

  // Called at a negedge: check this cycle's outputs, drive inputs, advance model past the posedge.
  task automatic step(input bit vld, input upd_t w, output bit acc);
    bit blk;
    chk("occ",    32'(occ), 32'(mq.size()));
    chk("in_rdy", 32'(bus.o_in_rdy), 32'(mq.size() != DEPTH));
    chk("stall",  32'(stall), 32'(mq.size() != 0 && m_blocked()));
    chk("upd_vld", 32'(bus.o_upd_vld), 32'(m_vld));
    chk("upd_data", {2'b00, bus.o_upd_prod_id, bus.o_upd_cmd, bus.o_upd_key, bus.o_upd_size},
        32'(m_out));
    bus.i_in_vld     = vld;
    bus.i_in_prod_id = w.prod_id;
    bus.i_in_cmd     = w.cmd;
    bus.i_in_key     = w.key;
    bus.i_in_size    = w.size;
    @(posedge clk);
    acc = vld && (mq.size() != DEPTH);
    blk = m_blocked();
    if (mq.size() != 0 && !blk) begin
      m_out = mq.pop_front();
      m_vld = 1'b1;
      last_out[m_out.prod_id] = cyc + 1;
    end else begin
      m_vld = 1'b0;
    end
    if (acc && w.cmd != CMD_NOP) mq.push_back(w);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, acc);
  endtask

  task automatic push(input upd_t w);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 100;
    while (!acc && budget > 0) begin
      step(1'b1, w, acc);
      budget--;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    bus.i_in_vld = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_upd_vld", 32'(bus.o_upd_vld), 32'd0);
    chk("rst_occ",     32'(occ), 32'd0);
    chk("rst_stall",   32'(stall), 32'd0);
    chk("rst_data", {2'b00, bus.o_upd_prod_id, bus.o_upd_cmd, bus.o_upd_key, bus.o_upd_size}, 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_rdy", 32'(bus.o_in_rdy), 32'd1);
  endtask

  initial begin
    bit   acc;
    int   budget;
    upd_t w;

    bus.i_in_vld     = 1'b0;
    bus.i_in_prod_id = '0;
    bus.i_in_cmd     = CMD_NOP;
    bus.i_in_key     = '0;
    bus.i_in_size    = '0;
    m_reset();

    @(negedge clk);
    do_reset();
    idle(2);

    // 1: single insert, two-cycle latency
    step(1'b1, mk(5, CMD_INSERT, 16'h1234, 16), acc);
    chk("t1_occ1", 32'(occ), 32'd1);
    chk("t1_vld_early", 32'(bus.o_upd_vld), 32'd0);
    step(1'b0, '0, acc);
    chk("t1_vld", 32'(bus.o_upd_vld), 32'd1);
    chk("t1_key", 32'(bus.o_upd_key), 32'h1234);
    chk("t1_size", 32'(bus.o_upd_size), 32'd16);
    chk("t1_occ0", 32'(occ), 32'd0);
    idle(4);

    // 2: same id back-to-back
    push(mk(3, CMD_INSERT, 16'h0001, 1));
    push(mk(3, CMD_DELETE, 16'h0002, 2));
    idle(8);

    // 3: head-of-line blocking, no reordering
    push(mk(3, CMD_INSERT, 16'h0010, 3));
    push(mk(4, CMD_REPLACE, 16'h0011, 4));
    push(mk(3, CMD_DELETE, 16'h0012, 5));
    idle(8);

    // 4: nine same-id commands against a depth-8 FIFO
    for (int i = 0; i < 9; i++) push(mk(7, CMD_INSERT, 16'h0700 + i, i));
    idle(40);

    // 5: NOP completes the handshake without enqueue
    step(1'b1, mk(2, CMD_NOP, 16'h0BAD, 9), acc);
    chk("t5_acc", 32'(acc), 32'd1);
    chk("t5_occ", 32'(occ), 32'd0);
    idle(4);

    // 6: reset during drain at occupancy 5
    for (int i = 0; i < 8; i++) push(mk(7, CMD_REPLACE, 16'h7700 + i, i));
    budget = 60;
    while (mq.size() != 5 && budget > 0) begin
      idle(1);
      budget--;
    end
    chk("t6_reach_occ5", 32'(mq.size()), 32'd5);
    do_reset();
    idle(10);

    // random traffic over a small id set to exercise hazards
    for (int i = 0; i < 3000; i++) begin
      w.prod_id = id_t'($urandom_range(0, 3));
      w.cmd     = cmd_t'($urandom_range(0, 3));
      w.key     = key_t'($urandom);
      w.size    = size_t'($urandom);
      if (i == 1500) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 65), w, acc);
      end
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

endmodule
